// File: rtl/iob_bus_split_n_pkg.sv
// Shared types and width helpers for the N-way IOb bus splitter.
// The FSM state encoding is fixed so that waveforms and debug probes stay stable.
package iob_bus_split_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERR   = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  // Width of the slave-select field. Never less than one bit.
  function automatic int sel_width(input int n_slaves);
    return (n_slaves > 1) ? $clog2(n_slaves) : 1;
  endfunction

  // Width of the watchdog counter. Never less than one bit.
  function automatic int timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/iob_bus_split_n_timer.sv
// Saturating watchdog counter: counts 0..TIMEOUT-1 while enabled, never wraps.
// expire is high while enabled and the last count has been reached.
module iob_bus_split_n_timer
  import iob_bus_split_n_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_reg;
  logic [TW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != LAST)) begin
      count_next = count_reg + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expire = enable && (count_reg == LAST);

endmodule

// File: rtl/iob_bus_split_n.sv
// N-way splitter for the IOb native bus: decodes a slave from an address field, forwards the
// registered request, and answers with an error if the select is invalid or the slave times out.
module iob_bus_split_n
  import iob_bus_split_n_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_LSB  = 28,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic                       err_flag,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [N_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ready
);

  localparam int SEL_W  = sel_width(N_SLAVES);
  localparam int STRB_W = DATA_W / 8;

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic [SEL_W-1:0]    sel_reg;
  logic                err_flag_reg;
  logic [ADDR_W-1:0]   err_addr_reg;

  logic [SEL_W-1:0]    m_sel;
  logic                sel_ok;
  logic                accept;
  logic [N_SLAVES-1:0] sel_onehot;
  logic [DATA_W-1:0]   rdata_slot [N_SLAVES];
  logic [DATA_W-1:0]   rdata_sel;
  logic                ready_sel;
  logic                timer_expire;

  assign m_sel  = m_addr[SEL_LSB +: SEL_W];
  assign sel_ok = (32'(m_sel) < 32'(N_SLAVES));
  assign accept = (state_reg == ST_IDLE) && m_valid;

  // Decoder and read-data slices, one per slave port.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slot
      assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
      assign rdata_slot[gi] = s_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      rdata_sel = rdata_sel | (rdata_slot[i] & {DATA_W{sel_onehot[i]}});
    end
  end

  assign ready_sel = |(s_ready & sel_onehot);

  generate
    if (TIMEOUT != 0) begin : g_timer
      iob_bus_split_n_timer #(
        .TIMEOUT(TIMEOUT)
      ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_reg != ST_BUSY),
        .enable (state_reg == ST_BUSY),
        .expire (timer_expire)
      );
    end else begin : g_no_timer
      assign timer_expire = 1'b0;
    end
  endgenerate

  // GUARD absorbs the cycle in which the master may still show the completed request.
  always_comb begin
    state_next = state_reg;
    m_ready    = 1'b0;
    m_err      = 1'b0;
    m_rdata    = '0;
    s_valid    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (m_valid) begin
          state_next = sel_ok ? ST_BUSY : ST_ERR;
        end
      end
      ST_BUSY: begin
        s_valid = sel_onehot;
        if (ready_sel) begin
          m_ready    = 1'b1;
          m_rdata    = rdata_sel;
          state_next = ST_GUARD;
        end else if (timer_expire) begin
          state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        m_ready    = 1'b1;
        m_err      = 1'b1;
        state_next = ST_GUARD;
      end
      ST_GUARD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      sel_reg      <= '0;
      err_flag_reg <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= m_addr;
        wdata_reg <= m_wdata;
        wstrb_reg <= m_wstrb;
        sel_reg   <= m_sel;
      end
      if (state_reg == ST_ERR) begin
        err_flag_reg <= 1'b1;
        err_addr_reg <= addr_reg;
      end
    end
  end

  assign s_addr   = addr_reg;
  assign s_wdata  = wdata_reg;
  assign s_wstrb  = wstrb_reg;
  assign err_flag = err_flag_reg;
  assign err_addr = err_addr_reg;

endmodule
